// File: rtl/int8_mul_sched_if.sv
// rtl/int8_mul_sched_if.sv - request/result handshake bundle for int8_mul_sched
//
// Carries the per-requester operand streams (in_valid/in_ready/in_int8/in_act)
// and the single result stream (out_valid/out_ready/out_id/out_sign/out_exp/out_man).
// slave  : scheduler side (consumes requests, produces results)
// master : requester / downstream side
interface int8_mul_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    in_valid;
    logic [NUM_REQ-1:0]    in_ready;
    logic [NUM_REQ*8-1:0]  in_int8;
    logic [NUM_REQ*16-1:0] in_act;

    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic                  out_sign;
    logic [4:0]            out_exp;
    logic [18:0]           out_man;

    modport slave (
        input  in_valid, in_int8, in_act, out_ready,
        output in_ready, out_valid, out_id, out_sign, out_exp, out_man
    );

    modport master (
        output in_valid, in_int8, in_act, out_ready,
        input  in_ready, out_valid, out_id, out_sign, out_exp, out_man
    );
endinterface

// File: rtl/int8_mul_sched.sv
// rtl/int8_mul_sched.sv - round-robin shared FP16 x INT8 multiplier with 2-stage back-pressurable pipeline
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : int8_mul_sched_if.slave, request streams in, result stream out
//   issue_cnt : 16-bit wrapping count of accepted requests
//   busy      : either pipeline stage holds a valid entry
module int8_mul_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    int8_mul_sched_if.slave     bus,
    output logic [15:0]         issue_cnt,
    output logic                busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] grant;
    logic               granted;
    logic               accept;
    logic [7:0]         win_int8;
    logic [15:0]        win_act;

    logic               s1_valid;
    logic               s1_load;
    logic [ID_W-1:0]    s1_id;
    logic [7:0]         s1_int8;
    logic [15:0]        s1_act;

    logic               s2_valid;
    logic               s2_load;
    logic [ID_W-1:0]    s2_id;
    logic               s2_sign;
    logic [4:0]         s2_exp;
    logic [18:0]        s2_man;

    logic [7:0]         mag;
    logic [10:0]        sig;
    logic               p_sign;
    logic [4:0]         p_exp;
    logic [18:0]        p_man;

    // Rotating-priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        granted  = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!granted && bus.in_valid[idx]) begin
                granted     = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Winner operand mux, driven from the one-hot grant.
    always_comb begin
        win_int8 = '0;
        win_act  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_int8 = bus.in_int8[8*i +: 8];
                win_act  = bus.in_act[16*i +: 16];
            end
        end
    end

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;

    // rst_n gates the handshake so nothing is offered while reset is held,
    // even though both stages already read as empty.
    assign bus.in_ready = grant & {NUM_REQ{s1_load && rst_n}};
    assign accept       = granted && s1_load && rst_n;

    // Product of the S1 operands. |-128| fits the 8-bit magnitude as 128.
    assign mag    = s1_int8[7] ? (~s1_int8 + 8'd1) : s1_int8;
    assign sig    = {|s1_act[14:10], s1_act[9:0]};
    assign p_sign = s1_int8[7] ^ s1_act[15];
    assign p_exp  = s1_act[14:10] - 5'd15;
    assign p_man  = 19'(mag) * 19'(sig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            issue_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_int8   <= '0;
            s1_act    <= '0;
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_man    <= '0;
        end else begin
            if (accept) begin
                rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_id   <= grant_id;
                    s1_int8 <= win_int8;
                    s1_act  <= win_act;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_id   <= s1_id;
                    s2_sign <= p_sign;
                    s2_exp  <= p_exp;
                    s2_man  <= p_man;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_id    = s2_id;
    assign bus.out_sign  = s2_sign;
    assign bus.out_exp   = s2_exp;
    assign bus.out_man   = s2_man;
    assign busy          = s1_valid || s2_valid;
endmodule

// File: tb/tb_int8_mul_sched.sv
// tb/tb_int8_mul_sched.sv - scoreboard bench for int8_mul_sched
module tb_int8_mul_sched;
    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic        sign;
        logic [4:0]  exp;
        logic [18:0] man;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] issue_cnt;
    logic        busy;

    always #5 clk = ~clk;

    int8_mul_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    int8_mul_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .issue_cnt (issue_cnt),
        .busy      (busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    res_t sb_q[$];
    int   order_q[$];

    logic [7:0]  t_int8 [4];
    logic [15:0] t_act  [4];
    res_t        t_res  [4];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] cur_out();
        return 64'({bus.out_valid, bus.out_id, bus.out_sign, bus.out_exp, bus.out_man});
    endfunction

    // Monitor: every accepted result is compared against the head of the scoreboard.
    always @(negedge clk) begin
        res_t got;
        res_t want;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got = {bus.out_id, bus.out_sign, bus.out_exp, bus.out_man};
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", got);
            end else begin
                want = sb_q.pop_front();
                check("result", 64'(got), 64'(want));
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] w, input logic [15:0] a);
        bus.in_int8[8*i +: 8]   = w;
        bus.in_act[16*i +: 16]  = a;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) set_req(i, t_int8[i], t_act[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_fields"}, 64'({bus.out_id, bus.out_sign, bus.out_exp, bus.out_man}), 64'd0);
        check({tag, "_issue_cnt"}, 64'(issue_cnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || sb_q.size() != 0) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic single_req(input int id, input logic [7:0] w, input logic [15:0] a,
                              input res_t r, input bit chk_lat);
        logic [3:0] one;
        bit got;
        one = 4'b0001;
        got = 1'b0;
        set_req(id, w, a);
        sb_q.push_back(r);
        exp_cnt++;
        bus.in_valid = one << id;
        for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            got = |(bus.in_valid & bus.in_ready);
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check("single_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = '0;
        if (chk_lat) begin
            @(negedge clk);
            check("latency_t1", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("latency_t2", 64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        wait_idle();
    endtask

    task automatic run_stream(input logic [3:0] mask, input int stall_start, input int stall_len);
        int   n;
        int   acc;
        int   cyc;
        logic [3:0] one;
        logic [63:0] held;
        bit   stalled;
        n    = order_q.size();
        acc  = 0;
        cyc  = 0;
        one  = 4'b0001;
        held = '0;
        foreach (order_q[k]) begin
            sb_q.push_back(t_res[order_q[k]]);
            exp_cnt++;
        end
        bus.in_valid = mask;
        while (acc < n && cyc < 200) begin
            stalled = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            bus.out_ready = !stalled;
            @(negedge clk);
            if (stalled) begin
                if (cyc == stall_start) held = cur_out();
                else check("stall_hold", cur_out(), held);
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (|(bus.in_valid & bus.in_ready)) begin
                check("grant_order", 64'(bus.in_valid & bus.in_ready), 64'(one << order_q[acc]));
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc == n) bus.in_valid = '0;
        end
        check("stream_accepts", 64'(acc), 64'(n));
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        wait_idle();
        check("issue_cnt", 64'(issue_cnt), 64'(exp_cnt));
    endtask

    initial begin
        t_int8[0] = 8'h01; t_act[0] = 16'h3C00; t_res[0] = '{2'd0, 1'b0, 5'h00, 19'h00400};
        t_int8[1] = 8'hFF; t_act[1] = 16'h4000; t_res[1] = '{2'd1, 1'b1, 5'h01, 19'h00400};
        t_int8[2] = 8'h02; t_act[2] = 16'hBC00; t_res[2] = '{2'd2, 1'b1, 5'h00, 19'h00800};
        t_int8[3] = 8'h10; t_act[3] = 16'h3800; t_res[3] = '{2'd3, 1'b0, 5'h1F, 19'h04000};

        bus.in_valid  = 4'hF;
        bus.in_int8   = '0;
        bus.in_act    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        bus.in_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        single_req(2, 8'h03, 16'h3C00, '{2'd2, 1'b0, 5'h00, 19'h00C00}, 1'b1);
        check("issue_cnt_single", 64'(issue_cnt), 64'd1);

        single_req(0, 8'h80, 16'hC000, '{2'd0, 1'b0, 5'h01, 19'h20000}, 1'b0);
        single_req(0, 8'h7F, 16'h0001, '{2'd0, 1'b0, 5'h11, 19'h0007F}, 1'b0);

        load_table();
        order_q = '{1, 3, 1, 3, 1, 3};
        run_stream(4'b1010, -1, 0);

        order_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        run_stream(4'b1111, -1, 0);

        order_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        run_stream(4'b1111, 3, 3);

        // Fill both stages under backpressure, then reset mid-operation.
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        sb_q.delete();
        exp_cnt = 0;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 64'(bus.in_ready), 64'h1);
        sb_q.push_back(t_res[0]);
        exp_cnt++;
        @(posedge clk); #1;
        bus.in_valid = '0;
        wait_idle();
        check("issue_cnt_post_reset", 64'(issue_cnt), 64'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int8_mul_sched.md
# int8_mul_sched

Round-robin scheduler that shares one FP16×INT8 multiplier datapath among NUM_REQ requesters (per-lane weight/activation sources in the FMA array). Each requester presents an INT8 weight and an FP16 activation with a valid/ready handshake. The block arbitrates and registers the operands, computes the unnormalized product, and returns it with the requester ID through a 2-stage, back-pressurable pipeline. It sits between the operand fetch logic and the FP16 accumulator/normalizer.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_REQ  request valid, bit i = requester i
- in_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- in_int8  in  NUM_REQ*8  two's-complement weight, requester i at [8i+7:8i]
- in_act  in  NUM_REQ*16  FP16 activation, requester i at [16i+15:16i]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_id  out  ID_W  requester ID of result
- out_sign  out  1  product sign
- out_exp  out  5  unbiased activation exponent, mod 32
- out_man  out  19  unsigned mantissa product
- issue_cnt  out  16  accepted-request counter, wraps
- busy  out  1  any pipeline stage valid

## Operation
- Arbitration (combinational): starting at pointer rr_ptr, grant the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
- in_ready[i] = grant[i] & s1_load. At most one bit set. in_ready must not depend on in_valid of the same requester beyond the grant search.
- Accept = |(in_valid & in_ready). On accept, rr_ptr <= granted_id+1 mod NUM_REQ. With no accept, rr_ptr holds.
- Stage 1 (S1) registers s1_valid, id, int8 and act of the winner.
- Stage 2 (S2) registers the product computed from S1:
  - sign = int8[7] ^ act[15]
  - exp = act[14:10] − 15, 5-bit wrap
  - man = |int8| (8-bit unsigned, so |−128| = 128) × {act[14:10]≠0, act[9:0]} (11 bits), full 19-bit result
- Outputs are driven directly from S2 registers: out_valid = s2_valid.
- Flow control:
  - s2_load = !s2_valid | out_ready
  - s1_load = !s1_valid | s2_load
  - S2 takes S1 when s2_load. s2_valid <= s1_valid.
  - S1 takes the winner when s1_load. s1_valid <= accept.
- issue_cnt increments by 1 on every accept and wraps 0xFFFF→0.
- busy = s1_valid | s2_valid.
- No special handling of FP16 Inf/NaN: exponent 31 passes through as 16 with the hidden bit set.

## Timing
- Reset (async assert, synchronous-release behaviour assumed by the reset tree):
  - rr_ptr=0, s1_valid=0, s2_valid=0, issue_cnt=0
  - out_valid=0, out_id=0, out_sign=0, out_exp=0, out_man=0, busy=0
  - in_ready=0 only while rst_n is low; grant is valid from the first cycle after release.
- Latency: a request accepted in cycle t gives out_valid in cycle t+2, provided out_ready was not low in t+1.
- Throughput: 1 result/cycle with out_ready held high.
- Output is held stable (all out_* fields) while out_valid=1 and out_ready=0.
- Full stall: with S1 and S2 valid and out_ready=0, in_ready=0 for all requesters.
- Drain-and-fill in one cycle: if S2 fires while S1 is valid, S1 may accept a new request in that same cycle.
- Reset asserted mid-operation: in-flight results are discarded. No result appears after rst_n rises until new accepts occur.
- A requester that drops in_valid without being granted is legal. It does not affect rr_ptr.

## Test plan
- Single request, requester 2: int8=0x03, act=0x3C00, out_ready=1.
  - Accept at t, out_valid at t+2 with id=2, sign=0, exp=0, man=0x00C00.
  - issue_cnt=1 afterwards.
- Extreme values, requester 0: int8=0x80, act=0xC000 → sign=0, exp=1, man=0x20000. Then int8=0x7F, act=0x0001 (subnormal) → sign=0, exp=0x11, man=0x0007F.
- Fairness: all 4 requesters valid continuously, out_ready=1.
  - Accepts in order 0,1,2,3,0,1,… one per cycle.
  - out_id follows the same order 2 cycles later.
- Fairness with a partial set: only requesters 1 and 3 valid → alternating 1,3,1,3.
- Backpressure: stream requests, then drop out_ready for 3 cycles.
  - out_* are held constant and in_ready goes all-zero once S1 and S2 are full.
  - On out_ready=1, results resume with no loss, duplication or reordering.
- Reset mid-stream: assert rst_n=0 while busy=1.
  - All outputs and issue_cnt go to 0 immediately.
  - After release, the first grant goes to the lowest valid index (rr_ptr=0).
